song_reader: RTL and testbench

SONG_READER -- requirements
Module: song_reader

---
 rtl/song_reader.sv | 160 ++++++++++++++++
 tb/tb_song_reader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// Song sequencer: steps through a 4x32 song ROM and hands each note/duration to the note player.
// Optional build macro SONG_READER_LOOP_EN: repeat the song forever instead of stopping at its end.
module song_reader (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic [1:0] song,
  input  logic       note_done,
  output logic [5:0] note_to_load,
  output logic [5:0] duration_to_load,
  output logic       load_new_note,
  output logic       song_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ROM_WAIT,
    LOAD,
    ARM,
    WAIT_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [5:0]  note_q, note_d;
  logic [5:0]  dur_q, dur_d;
  logic        load_q, load_d;
  logic        done_q, done_d;
  logic [1:0]  song_q;
  logic        armed_q;
  logic [11:0] rom_q;
  logic        song_change;

  // Song table, word = {note[5:0], duration[5:0]}; duration 0 marks the end of a song.
  function automatic logic [11:0] rom_word(input logic [1:0] s, input logic [4:0] i);
    logic [5:0] n;
    logic [5:0] d;
    n = 6'd0;
    d = 6'd0;
    case (s)
      2'd0: begin
        n = 6'(i) + 6'd5;
        d = 6'(i) + 6'd10;
      end
      2'd1: begin
        case (i)
          5'd0:    begin n = 6'd12; d = 6'd8; end
          5'd1:    begin n = 6'd0;  d = 6'd4; end
          default: begin n = 6'd0;  d = 6'd0; end
        endcase
      end
      2'd2: begin
        n = 6'd40 - 6'(i);
        d = 6'(i) + 6'd20;
      end
      default: begin
        n = 6'(i);
        d = 6'd2;
      end
    endcase
    return {n, d};
  endfunction

  // NOTE: the ROM output register is a memory read port, so it carries no reset.
  always_ff @(posedge clk) begin
    rom_q <= rom_word(song, idx_q);
  end

  assign song_change = armed_q && (song != song_q);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    note_d  = note_q;
    dur_d   = dur_q;
    load_d  = 1'b0;
`ifdef SONG_READER_LOOP_EN
    done_d  = 1'b0;
`else
    done_d  = done_q;
`endif

    if (song_change) begin
      idx_d   = 5'd0;
      done_d  = 1'b0;
      state_d = play ? FETCH : IDLE;
    end else if (play) begin
      case (state_q)
        IDLE:     if (!done_q) state_d = FETCH;
        FETCH:    state_d = ROM_WAIT;
        ROM_WAIT: begin
          if (rom_q[5:0] == 6'd0) begin
            done_d = 1'b1;
`ifdef SONG_READER_LOOP_EN
            idx_d   = 5'd0;
            state_d = FETCH;
`else
            state_d = IDLE;
`endif
          end else begin
            note_d  = rom_q[11:6];
            dur_d   = rom_q[5:0];
            load_d  = 1'b1;
            state_d = LOAD;
          end
        end
        LOAD:     state_d = ARM;
        ARM:      state_d = WAIT_DONE;
        WAIT_DONE: begin
          if (note_done) begin
            if (idx_q == 5'd31) begin
              done_d = 1'b1;
`ifdef SONG_READER_LOOP_EN
              idx_d   = 5'd0;
              state_d = FETCH;
`else
              state_d = IDLE;
`endif
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = FETCH;
            end
          end
        end
        default:  state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      note_q  <= 6'd0;
      dur_q   <= 6'd0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      song_q  <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      load_q  <= load_d;
      done_q  <= done_d;
      song_q  <= song;
      armed_q <= 1'b1;
    end
  end

  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;
  assign load_new_note    = load_q;
  assign song_done        = done_q;

endmodule

// File: tb/tb_song_reader.sv
// Directed self-checking bench for song_reader; expected notes are hand-derived from the song table.
module tb_song_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       play;
  logic [1:0] song;
  logic       note_done;
  logic [5:0] note_to_load;
  logic [5:0] duration_to_load;
  logic       load_new_note;
  logic       song_done;

  int n_vec  = 0;
  int n_miss = 0;

  song_reader dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .song             (song),
    .note_done        (note_done),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .song_done        (song_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_loads(input int n, output int loads);
    loads = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (load_new_note) loads++;
    end
  endtask

  // Waits (bounded) for the next load pulse and checks latency and payload.
  task automatic expect_load(input string tag, input int exp_cyc, input int exp_note,
                             input int exp_dur);
    int cyc;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!load_new_note && cyc < exp_cyc + 8);
    check({tag, "_lat"}, cyc, exp_cyc);
    check({tag, "_note"}, note_to_load, exp_note);
    check({tag, "_dur"}, duration_to_load, exp_dur);
  endtask

  initial begin
    int loads;
    reset     = 1'b1;
    play      = 1'b0;
    song      = 2'd0;
    note_done = 1'b0;
    tick();
    tick();
    check("rst_note", note_to_load, 0);
    check("rst_dur", duration_to_load, 0);
    check("rst_load", load_new_note, 0);
    check("rst_done", song_done, 0);

    // Basic load: pulse on the third edge after release.
    reset = 1'b0;
    play  = 1'b1;
    count_loads(2, loads);
    check("basic_early", loads, 0);
    expect_load("basic", 1, 5, 10);

    // Advance with note_done held high: next load 5 cycles later.
    note_done = 1'b1;
    expect_load("adv", 5, 6, 11);
    note_done = 1'b0;
    tick();
    check("pulse_width", load_new_note, 0);
    tick();

    // Pause in WAIT_DONE with note_done=1.
    play      = 1'b0;
    note_done = 1'b1;
    count_loads(20, loads);
    check("pause_loads", loads, 0);
    check("pause_note", note_to_load, 6);
    check("pause_dur", duration_to_load, 11);
    play = 1'b1;
    expect_load("resume", 3, 7, 12);

    for (int i = 3; i <= 7; i++) expect_load("s0_step", 5, i + 5, i + 10);

    // Song change 0 -> 2 while waiting on note 7.
    note_done = 1'b0;
    tick();
    tick();
    tick();
    song = 2'd2;
    expect_load("chg", 3, 40, 20);
    check("chg_done", song_done, 0);

    // Async reset between edges while in LOAD.
    #2;
    reset = 1'b1;
    #1;
    check("arst_load", load_new_note, 0);
    check("arst_note", note_to_load, 0);
    check("arst_dur", duration_to_load, 0);
    check("arst_done", song_done, 0);
    song      = 2'd1;
    note_done = 1'b1;
    tick();
    reset = 1'b0;
    expect_load("restart", 3, 12, 8);

    // End marker at song 1 index 2; index 1 is a rest.
    expect_load("rest", 5, 0, 4);
    count_loads(5, loads);
    check("end_loads", loads, 0);
    check("end_done", song_done, 1);
`ifdef SONG_READER_LOOP_EN
    expect_load("end_loop", 2, 12, 8);
    check("end_loop_done", song_done, 0);
`else
    count_loads(30, loads);
    check("end_hold_loads", loads, 0);
    check("end_hold_done", song_done, 1);
`endif

    // Full 32-entry song ending at index 31.
    song = 2'd3;
    expect_load("s3_first", 3, 0, 2);
    check("s3_done_clr", song_done, 0);
    for (int i = 1; i <= 31; i++) expect_load("s3_step", 5, i, 2);
    count_loads(3, loads);
    check("s3_end_loads", loads, 0);
    check("s3_end_done", song_done, 1);
`ifdef SONG_READER_LOOP_EN
    expect_load("s3_wrap", 2, 0, 2);
    check("s3_wrap_done", song_done, 0);
`else
    count_loads(20, loads);
    check("s3_hold_loads", loads, 0);
    check("s3_hold_note", note_to_load, 31);
    check("s3_hold_done", song_done, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
